// File: rtl/vram_tile_row_reader.sv
// vram_tile_row_reader: fetches one 8-pixel row from the combinational tile RAM and serializes it.
// Optional TILE_ROW_FLIP_EN adds vertical row mirroring and horizontal emission reversal.
module vram_tile_row_reader #(
   parameter int ADDR_W = 12,
   parameter int PIX_W  = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic [ADDR_W-1:0]  req_tile,
   input  logic [2:0]         req_row,
   input  logic               req_hflip,
   input  logic               req_vflip,
   output logic [ADDR_W-1:0]  mem_addr,
   input  logic [64*PIX_W-1:0] mem_data,
   output logic               pix_valid,
   input  logic               pix_ready,
   output logic [PIX_W-1:0]   pix_data,
   output logic [2:0]         pix_x,
   output logic               pix_last,
   output logic               busy
);
   localparam int ROW_W = 8*PIX_W;
   typedef enum logic [1:0] {IDLE, FETCH, EMIT} state_t;
   state_t state, state_next;
   logic [2:0] row_q, row_eff, count, col;
   logic [ROW_W-1:0] row_sel, row_buf;
   logic [PIX_W-1:0] pix_sel;
   logic accept, take;
`ifdef TILE_ROW_FLIP_EN
   logic hflip_q;
   assign row_eff = req_vflip ? ~req_row : req_row;
   assign col = hflip_q ? ~count : count;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) hflip_q <= 1'b0;
      else if (accept) hflip_q <= req_hflip;
`else
   logic unused_flip;
   assign unused_flip = req_hflip | req_vflip;
   assign row_eff = req_row;
   assign col = count;
`endif
   assign accept = state == IDLE && req_valid;
   assign take = state == EMIT && pix_ready;
   // Row r occupies the r-th 32-bit word counted from the MSB end; same for columns within a row.
   always_comb begin
      row_sel = '0;
      for (int i = 0; i < 8; i++)
         if (row_q == 3'(i)) row_sel = mem_data[(7-i)*ROW_W +: ROW_W];
   end
   always_comb begin
      pix_sel = '0;
      for (int i = 0; i < 8; i++)
         if (col == 3'(i)) pix_sel = row_buf[(7-i)*PIX_W +: PIX_W];
   end
   always_comb begin
      state_next = state;
      state_next = accept ? FETCH :
                   state == FETCH ? EMIT :
                   (take && count == 3'd7) ? IDLE : state;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= state_next;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         mem_addr <= '0;
         row_q    <= '0;
         row_buf  <= '0;
         count    <= '0;
      end else begin
         if (accept) begin
            mem_addr <= req_tile;
            row_q    <= row_eff;
         end
         if (state == FETCH) begin
            row_buf <= row_sel;
            count   <= '0;
         end else if (take) count <= count + 3'd1;
      end
   assign req_ready = state == IDLE;
   assign busy      = state != IDLE;
   assign pix_valid = state == EMIT;
   assign pix_data  = pix_valid ? pix_sel : '0;
   assign pix_x     = pix_valid ? col : '0;
   assign pix_last  = pix_valid && count == 3'd7;
endmodule

// File: tb/tb_vram_tile_row_reader.sv
// tb_vram_tile_row_reader: directed self-checking bench with a behavioural tile RAM.
module tb_vram_tile_row_reader;
   logic clk, rst_n, req_valid, req_ready, req_hflip, req_vflip;
   logic [11:0] req_tile, mem_addr;
   logic [2:0] req_row, pix_x;
   logic [255:0] mem_data;
   logic pix_valid, pix_ready, pix_last, busy;
   logic [3:0] pix_data;
   logic [255:0] ram [0:4095];
   int pass_cnt = 0, total = 0;

   vram_tile_row_reader dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_tile(req_tile), .req_row(req_row), .req_hflip(req_hflip), .req_vflip(req_vflip),
      .mem_addr(mem_addr), .mem_data(mem_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
      .pix_data(pix_data), .pix_x(pix_x), .pix_last(pix_last), .busy(busy)
   );

   assign mem_data = ram[mem_addr];
   initial clk = 0;
   always #5 clk = ~clk;

   task automatic set_row(input int t, input int r, input logic [31:0] w);
      ram[t][(7-r)*32 +: 32] = w;
   endtask

   task automatic send_req(input logic [11:0] t, input logic [2:0] r, input logic hf, input logic vf);
      req_valid = 1; req_tile = t; req_row = r; req_hflip = hf; req_vflip = vf;
      @(negedge clk);
      req_valid = 0;
   endtask

   task automatic test_reset;
      total++;
      if ({req_ready, busy, pix_valid, pix_data, pix_x, pix_last, mem_addr} !== {1'b1, 1'b0, 1'b0, 4'h0, 3'd0, 1'b0, 12'h0})
         $display("FAIL reset_outputs: got rdy=%b busy=%b pv=%b pd=%h px=%0d pl=%b addr=%h expected 1 0 0 0 0 0 000",
                  req_ready, busy, pix_valid, pix_data, pix_x, pix_last, mem_addr);
      else pass_cnt++;
   endtask

   task automatic test_basic;
      send_req(12'h005, 3'd2, 1'b0, 1'b0);
      total++;
      if ({busy, req_ready, pix_valid, mem_addr} !== {1'b1, 1'b0, 1'b0, 12'h005})
         $display("FAIL basic_fetch: got busy=%b rdy=%b pv=%b addr=%h expected 1 0 0 005", busy, req_ready, pix_valid, mem_addr);
      else pass_cnt++;
      @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         total++;
         if ({pix_valid, pix_data, pix_x, pix_last} !== {1'b1, 4'(i), 3'(i), i == 7})
            $display("FAIL basic_pix%0d: got v=%b d=%h x=%0d l=%b expected 1 %h %0d %b",
                     i, pix_valid, pix_data, pix_x, pix_last, 4'(i), i, i == 7);
         else pass_cnt++;
         @(negedge clk);
      end
      total++;
      if ({req_ready, busy, pix_valid, mem_addr} !== {1'b1, 1'b0, 1'b0, 12'h005})
         $display("FAIL basic_done: got rdy=%b busy=%b pv=%b addr=%h expected 1 0 0 005", req_ready, busy, pix_valid, mem_addr);
      else pass_cnt++;
   endtask

   task automatic test_backpressure;
      int p = 0, stall = 0;
      send_req(12'h005, 3'd2, 1'b0, 1'b0);
      @(negedge clk);
      set_row(5, 2, 32'hFFFF_FFFF);
      for (int c = 0; c < 20 && p < 8; c++) begin
         total++;
         if ({pix_valid, pix_data, pix_x, pix_last} !== {1'b1, 4'(p), 3'(p), p == 7})
            $display("FAIL bp_pix%0d_c%0d: got v=%b d=%h x=%0d l=%b expected 1 %h %0d %b",
                     p, c, pix_valid, pix_data, pix_x, pix_last, 4'(p), p, p == 7);
         else pass_cnt++;
         pix_ready = !(p == 4 && stall < 3);
         if (!pix_ready) stall++;
         @(negedge clk);
         if (pix_ready) p++;
      end
      pix_ready = 1;
      total++;
      if ({p, stall} !== {32'd8, 32'd3})
         $display("FAIL bp_count: got pixels=%0d stalls=%0d expected 8 3", p, stall);
      else pass_cnt++;
      total++;
      if ({req_ready, pix_valid} !== 2'b10)
         $display("FAIL bp_done: got rdy=%b pv=%b expected 1 0", req_ready, pix_valid);
      else pass_cnt++;
      set_row(5, 2, 32'h0123_4567);
   endtask

   task automatic test_back_to_back;
      int acc [2];
      int n_acc = 0, lasts = 0;
      logic took;
      set_row(12'h7FF, 1, 32'h1111_1111);
      set_row(0, 1, 32'h2222_2222);
      req_valid = 1; req_tile = 12'h7FF; req_row = 3'd1; pix_ready = 1;
      for (int c = 0; c < 40 && n_acc < 2; c++) begin
         took = req_ready;
         if (took) begin acc[n_acc] = c; n_acc++; end
         if (pix_valid && pix_last) lasts++;
         @(negedge clk);
         if (took) begin
            total++;
            if (mem_addr !== (n_acc == 1 ? 12'h7FF : 12'h000))
               $display("FAIL b2b_addr%0d: got %h expected %h", n_acc, mem_addr, n_acc == 1 ? 12'h7FF : 12'h000);
            else pass_cnt++;
            req_tile = 12'h000;
         end
      end
      req_valid = 0;
      total++;
      if (n_acc !== 2) $display("FAIL b2b_accepts: got %0d expected 2", n_acc);
      else pass_cnt++;
      if (n_acc == 2) begin
         total++;
         if (acc[1] - acc[0] !== 10) $display("FAIL b2b_spacing: got %0d expected 10", acc[1] - acc[0]);
         else pass_cnt++;
      end
      total++;
      if (lasts !== 1) $display("FAIL b2b_lasts: got %0d expected 1", lasts);
      else pass_cnt++;
      for (int c = 0; c < 20 && !req_ready; c++) @(negedge clk);
      total++;
      if (req_ready !== 1'b1) $display("FAIL b2b_drain: got rdy=%b expected 1", req_ready);
      else pass_cnt++;
   endtask

   task automatic test_flip;
      logic [31:0] w;
      logic [2:0] cx;
      logic [3:0] d;
      set_row(12'h0A5, 7, 32'h89AB_CDEF);
      set_row(12'h0A5, 0, 32'h1357_9BDF);
      send_req(12'h0A5, 3'd0, 1'b1, 1'b1);
      @(negedge clk);
      for (int i = 0; i < 8; i++) begin
`ifdef TILE_ROW_FLIP_EN
         w = 32'h89AB_CDEF; cx = 3'(7 - i);
`else
         w = 32'h1357_9BDF; cx = 3'(i);
`endif
         d = w[(7-cx)*4 +: 4];
         total++;
         if ({pix_valid, pix_data, pix_x, pix_last} !== {1'b1, d, cx, i == 7})
            $display("FAIL flip_pix%0d: got v=%b d=%h x=%0d l=%b expected 1 %h %0d %b",
                     i, pix_valid, pix_data, pix_x, pix_last, d, cx, i == 7);
         else pass_cnt++;
         @(negedge clk);
      end
      req_hflip = 0; req_vflip = 0;
   endtask

   task automatic test_reset_mid;
      send_req(12'h005, 3'd2, 1'b0, 1'b0);
      repeat (3) @(negedge clk);
      total++;
      if ({pix_valid, pix_data} !== {1'b1, 4'h2})
         $display("FAIL rst_pre: got v=%b d=%h expected 1 2", pix_valid, pix_data);
      else pass_cnt++;
      rst_n = 0;
      #1;
      total++;
      if ({pix_valid, req_ready, busy, pix_last, mem_addr} !== {1'b0, 1'b1, 1'b0, 1'b0, 12'h000})
         $display("FAIL rst_mid: got pv=%b rdy=%b busy=%b pl=%b addr=%h expected 0 1 0 0 000",
                  pix_valid, req_ready, busy, pix_last, mem_addr);
      else pass_cnt++;
      @(negedge clk);
      rst_n = 1;
      repeat (2) @(negedge clk);
      total++;
      if ({pix_valid, req_ready, busy} !== 3'b010)
         $display("FAIL rst_no_resume: got pv=%b rdy=%b busy=%b expected 0 1 0", pix_valid, req_ready, busy);
      else pass_cnt++;
   endtask

   initial begin
      for (int t = 0; t < 4096; t++) ram[t] = '0;
      for (int r = 0; r < 8; r++) set_row(5, r, 32'hDEAD_BEEF);
      set_row(5, 2, 32'h0123_4567);
      rst_n = 0; req_valid = 0; req_tile = 0; req_row = 0; req_hflip = 0; req_vflip = 0; pix_ready = 1;
      repeat (2) @(negedge clk);
      test_reset;
      rst_n = 1;
      @(negedge clk);
      test_basic;
      test_backpressure;
      test_back_to_back;
      test_flip;
      test_reset_mid;
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end
endmodule
